// File: rtl/fc_layer_engine.sv
// Single fully-connected layer: sequential per-neuron fixed-point MAC plus bias,
// then arithmetic shift, saturation and optional ReLU, streamed out one result per neuron.
module fc_layer_engine #(
  parameter int IN_CELL  = 14,
  parameter int OUT_CELL = 10,
  parameter int DATA_W   = 16,
  parameter int FRAC     = 8,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              relu_en,
  input  logic              flat_we,
  input  logic [ADDR_W-1:0] flat_addr,
  input  logic [DATA_W-1:0] flat_value,
  input  logic              w_we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_value,
  output logic              busy,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_value,
  output logic              all_end
);
  localparam int W_DEPTH = OUT_CELL * (IN_CELL + 1);
  localparam int XA      = (IN_CELL > 1) ? $clog2(IN_CELL) : 1;
  localparam int WA      = $clog2(W_DEPTH);
  localparam int JW      = (OUT_CELL > 1) ? $clog2(OUT_CELL) : 1;
  localparam int PW      = 2 * DATA_W;
  localparam int ACC_W   = PW + $clog2(IN_CELL + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;

  state_t                   state_q;
  logic [XA-1:0]            i_q;
  logic [JW-1:0]            j_q;
  logic [WA-1:0]            base_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     relu_q;
  logic                     busy_q;
  logic                     out_valid_q;
  logic                     all_end_q;
  logic [ADDR_W-1:0]        out_addr_q;
  logic [DATA_W-1:0]        out_value_q;

  // Power-of-two depth so the counters index the arrays at their natural width.
  logic signed [DATA_W-1:0] x_mem [2**XA];
  logic signed [DATA_W-1:0] w_mem [2**WA];

  logic                     load_ok;
  logic signed [DATA_W-1:0] x_rd, w_rd, bias_first, bias_next;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] res_d;

  assign load_ok = (state_q == IDLE) || (state_q == DONE);

  always_ff @(posedge clk) begin
    if (load_ok && flat_we && (flat_addr < ADDR_W'(IN_CELL)))
      x_mem[flat_addr[XA-1:0]] <= flat_value;
    if (load_ok && w_we && (w_addr < ADDR_W'(W_DEPTH)))
      w_mem[w_addr[WA-1:0]] <= w_value;
  end

  assign x_rd       = x_mem[i_q];
  assign w_rd       = w_mem[base_q + WA'(i_q)];
  assign bias_first = w_mem[WA'(IN_CELL)];
  // Bias of neuron j+1 sits one row further on; only read while j < OUT_CELL-1.
  assign bias_next  = w_mem[base_q + WA'(2 * IN_CELL + 1)];

  assign prod     = PW'(x_rd) * PW'(w_rd);
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign shifted  = acc_q >>> FRAC;

  always_comb begin
    if (shifted > SAT_MAX)      res_d = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) res_d = SAT_MIN[DATA_W-1:0];
    else                        res_d = shifted[DATA_W-1:0];
    if (relu_q && res_d[DATA_W-1]) res_d = '0;
  end

  function automatic logic signed [ACC_W-1:0] bias_acc(input logic signed [DATA_W-1:0] b);
    logic signed [ACC_W-1:0] e;
    e = {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
    return e <<< FRAC;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      base_q      <= '0;
      acc_q       <= '0;
      relu_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      all_end_q   <= 1'b0;
      out_addr_q  <= '0;
      out_value_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= MAC;
            i_q     <= '0;
            j_q     <= '0;
            base_q  <= '0;
            acc_q   <= bias_acc(bias_first);
            relu_q  <= relu_en;
            busy_q  <= 1'b1;
          end
        end
        MAC: begin
          acc_q <= acc_q + prod_ext;
          if (i_q == XA'(IN_CELL - 1)) begin
            i_q     <= '0;
            state_q <= EMIT;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        EMIT: begin
          out_valid_q <= 1'b1;
          out_addr_q  <= ADDR_W'(j_q);
          out_value_q <= res_d;
          if (j_q == JW'(OUT_CELL - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end else begin
            j_q     <= j_q + 1'b1;
            base_q  <= base_q + WA'(IN_CELL + 1);
            acc_q   <= bias_acc(bias_next);
            state_q <= MAC;
          end
        end
        DONE: begin
          // all_end is shown for at least one cycle even if enable already fell.
          if (!enable && all_end_q) begin
            state_q   <= IDLE;
            all_end_q <= 1'b0;
          end else begin
            all_end_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_value = out_value_q;
  assign all_end   = all_end_q;
endmodule
